// File: rtl/registers_sb_pkg.sv
// rtl/registers_sb_pkg.sv - shared types and helpers for the scoreboarded register file
package registers_sb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int MaxReadPorts = 4;

  function automatic logic is_zero_reg(input logic [31:0] addr);
    return addr == 32'd0;
  endfunction

endpackage

// File: rtl/registers_sb_scoreboard.sv
// rtl/registers_sb_scoreboard.sv - per-register pending bits for outstanding loads and reserve-conflict pulse
module registers_sb_scoreboard
  import registers_sb_pkg::*;
#(
  parameter int AddressBitWidth = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [AddressBitWidth-1:0]      rsv,
  input  logic                            rsv_enable,
  input  logic [AddressBitWidth-1:0]      ld,
  input  logic                            ld_write_enable,
  output logic [(2**AddressBitWidth)-1:0] pending,
  output logic                            conflict
);

  logic rsv_valid;
  logic ld_valid;

  assign rsv_valid = rsv_enable && !is_zero_reg(32'(rsv));
  assign ld_valid  = ld_write_enable && !is_zero_reg(32'(ld));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      conflict <= 1'b0;
    end else if (!enable) begin
      pending  <= '0;
      conflict <= 1'b0;
    end else begin
      conflict <= rsv_valid && pending[rsv];
      // Set is applied after clear so a same-cycle re-reservation survives the completion.
      if (ld_valid)
        pending[ld] <= 1'b0;
      if (rsv_valid)
        pending[rsv] <= 1'b1;
    end
  end

endmodule

// File: rtl/registers_sb.sv
// rtl/registers_sb.sv - register file with load scoreboard and post-reset clear sweep; REGISTERS_SB_BYPASS_EN enables same-cycle forwarding
module registers_sb
  import registers_sb_pkg::*;
#(
  parameter int AddressBitWidth = 5,
  parameter int DataBitWidth    = 32,
  parameter int ReadPorts       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 ready,
  input  logic [ReadPorts*AddressBitWidth-1:0] rs,
  output logic [ReadPorts*DataBitWidth-1:0]    rs_data_out,
  output logic [ReadPorts-1:0]                 rs_pending,
  input  logic [AddressBitWidth-1:0]           rd,
  input  logic                                 rd_write_enable,
  input  logic [DataBitWidth-1:0]              rd_data_in,
  input  logic [AddressBitWidth-1:0]           rsv,
  input  logic                                 rsv_enable,
  input  logic [AddressBitWidth-1:0]           ld,
  input  logic                                 ld_write_enable,
  input  logic [DataBitWidth-1:0]              ld_data_in,
  output logic                                 conflict
);

  localparam int NumRegs = 2 ** AddressBitWidth;

  state_e                      state;
  state_e                      state_next;
  logic [AddressBitWidth-1:0]  counter;
  logic [DataBitWidth-1:0]     mem [NumRegs];
  logic [NumRegs-1:0]          pending;
  logic                        run;

  assign run   = (state == RUN);
  assign ready = run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      counter <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR)
        counter <= counter + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && counter == {AddressBitWidth{1'b1}})
      state_next = RUN;
  end

  // Storage has no reset; the sweep zeroes it, and reads are masked until the sweep ends.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[counter] <= '0;
    end else begin
      if (rd_write_enable && !is_zero_reg(32'(rd)))
        mem[rd] <= rd_data_in;
      if (ld_write_enable && !is_zero_reg(32'(ld)))
        mem[ld] <= ld_data_in;
    end
  end

  registers_sb_scoreboard #(
    .AddressBitWidth(AddressBitWidth)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .enable          (run),
    .rsv             (rsv),
    .rsv_enable      (rsv_enable),
    .ld              (ld),
    .ld_write_enable (ld_write_enable),
    .pending         (pending),
    .conflict        (conflict)
  );

  for (genvar i = 0; i < ReadPorts; i++) begin : g_read
    logic [AddressBitWidth-1:0] addr;
    logic [DataBitWidth-1:0]    data;
    logic                       pend;

    assign addr = rs[i*AddressBitWidth +: AddressBitWidth];

    always_comb begin
      data = mem[addr];
      pend = pending[addr];
`ifdef REGISTERS_SB_BYPASS_EN
      if (rd_write_enable && rd == addr)
        data = rd_data_in;
      if (ld_write_enable && ld == addr) begin
        data = ld_data_in;
        if (!(rsv_enable && rsv == addr))
          pend = 1'b0;
      end
`endif
      if (!run || is_zero_reg(32'(addr))) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign rs_data_out[i*DataBitWidth +: DataBitWidth] = data;
    assign rs_pending[i]                               = pend;
  end

endmodule

// File: tb/tb_registers_sb.sv
// tb/tb_registers_sb.sv - directed self-checking bench for registers_sb
module tb_registers_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RP = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           ready;
  logic [RP*AW-1:0] rs;
  logic [RP*DW-1:0] rs_data_out;
  logic [RP-1:0]  rs_pending;
  logic [AW-1:0]  rd;
  logic           rd_write_enable;
  logic [DW-1:0]  rd_data_in;
  logic [AW-1:0]  rsv;
  logic           rsv_enable;
  logic [AW-1:0]  ld;
  logic           ld_write_enable;
  logic [DW-1:0]  ld_data_in;
  logic           conflict;

  int n_checks = 0;
  int n_pass   = 0;

  registers_sb #(
    .AddressBitWidth(AW),
    .DataBitWidth   (DW),
    .ReadPorts      (RP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ready           (ready),
    .rs              (rs),
    .rs_data_out     (rs_data_out),
    .rs_pending      (rs_pending),
    .rd              (rd),
    .rd_write_enable (rd_write_enable),
    .rd_data_in      (rd_data_in),
    .rsv             (rsv),
    .rsv_enable      (rsv_enable),
    .ld              (ld),
    .ld_write_enable (ld_write_enable),
    .ld_data_in      (ld_data_in),
    .conflict        (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_write_enable = 1'b0;
    rsv_enable      = 1'b0;
    ld_write_enable = 1'b0;
  endtask

  task automatic set_rs(input int p, input logic [AW-1:0] a);
    rs[p*AW +: AW] = a;
    #1;
  endtask

  function automatic logic [31:0] rdata(input int p);
    return rs_data_out[p*DW +: DW];
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'd32);
  endtask

  initial begin
    int nonzero;
    rst = 1'b1;
    rs = '0;
    rd = '0; rd_data_in = '0; rsv = '0; ld = '0; ld_data_in = '0;
    idle();
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);

    // Writes and reserves held during the sweep must be ignored.
    rst = 1'b0;
    rd = 5'd6; rd_data_in = 32'h0000_0123; rd_write_enable = 1'b1;
    ld = 5'd8; ld_data_in = 32'h0000_0456; ld_write_enable = 1'b1;
    rsv = 5'd6; rsv_enable = 1'b1;
    set_rs(0, 5'd6);
    chk("clear_pending", 32'(rs_pending[0]), 32'd0);
    wait_ready("sweep_len");
    idle();
    #1;
    nonzero = 0;
    for (int r = 0; r < 32; r++) begin
      set_rs(0, AW'(r));
      if (rdata(0) != 32'd0 || rs_pending[0] != 1'b0)
        nonzero++;
    end
    chk("all_zero", 32'(nonzero), 32'd0);
    chk("no_conflict_after_clear", 32'(conflict), 32'd0);

    // Basic write and x0.
    rd = 5'd5; rd_data_in = 32'hDEAD_BEEF; rd_write_enable = 1'b1;
    set_rs(0, 5'd5);
`ifdef REGISTERS_SB_BYPASS_EN
    chk("wr_same_cycle", rdata(0), 32'hDEAD_BEEF);
`else
    chk("wr_same_cycle", rdata(0), 32'h0);
`endif
    tick();
    idle();
    chk("wr_basic", rdata(0), 32'hDEAD_BEEF);
    set_rs(1, 5'd5);
    chk("wr_basic_p1", rdata(1), 32'hDEAD_BEEF);
    rd = 5'd0; rd_data_in = 32'h1; rd_write_enable = 1'b1;
    tick();
    idle();
    set_rs(0, 5'd0);
    chk("x0_write", rdata(0), 32'h0);

    // Port collisions.
    rd = 5'd7; rd_data_in = 32'h11; rd_write_enable = 1'b1;
    ld = 5'd7; ld_data_in = 32'h22; ld_write_enable = 1'b1;
    tick();
    idle();
    set_rs(0, 5'd7);
    chk("same_reg_b_wins", rdata(0), 32'h22);
    rd = 5'd3; rd_data_in = 32'h33; rd_write_enable = 1'b1;
    ld = 5'd4; ld_data_in = 32'h44; ld_write_enable = 1'b1;
    tick();
    idle();
    set_rs(0, 5'd3);
    set_rs(1, 5'd4);
    chk("diff_reg_a", rdata(0), 32'h33);
    chk("diff_reg_b", rdata(1), 32'h44);

    // Scoreboard set / clear.
    rsv = 5'd9; rsv_enable = 1'b1;
    tick();
    idle();
    set_rs(0, 5'd9);
    chk("rsv_pending", 32'(rs_pending[0]), 32'd1);
    chk("rsv_other_clear", 32'(rs_pending[1]), 32'd0);
    chk("rsv_no_conflict", 32'(conflict), 32'd0);
    ld = 5'd9; ld_data_in = 32'h55; ld_write_enable = 1'b1;
    #1;
`ifdef REGISTERS_SB_BYPASS_EN
    chk("ld_pend_same_cycle", 32'(rs_pending[0]), 32'd0);
`else
    chk("ld_pend_same_cycle", 32'(rs_pending[0]), 32'd1);
`endif
    tick();
    idle();
    chk("ld_clears_pending", 32'(rs_pending[0]), 32'd0);
    chk("ld_data", rdata(0), 32'h55);
    rsv = 5'd9; rsv_enable = 1'b1;
    ld = 5'd9; ld_data_in = 32'h66; ld_write_enable = 1'b1;
    tick();
    idle();
    chk("rsv_ld_same_pending", 32'(rs_pending[0]), 32'd1);
    chk("rsv_ld_same_data", rdata(0), 32'h66);

    // Conflict pulse on re-reserve.
    ld = 5'd9; ld_write_enable = 1'b1;
    tick();
    idle();
    rsv = 5'd9; rsv_enable = 1'b1;
    tick();
    chk("conflict_first", 32'(conflict), 32'd0);
    tick();
    idle();
    chk("conflict_pulse", 32'(conflict), 32'd1);
    chk("conflict_pending", 32'(rs_pending[0]), 32'd1);
    tick();
    chk("conflict_drop", 32'(conflict), 32'd0);

    // Reserve of x0 and load to a non-pending register.
    rsv = 5'd0; rsv_enable = 1'b1;
    tick();
    rsv_enable = 1'b0;
    set_rs(1, 5'd0);
    chk("rsv_x0", 32'(rs_pending[1]), 32'd0);
    ld = 5'd10; ld_data_in = 32'hABCD; ld_write_enable = 1'b1;
    tick();
    idle();
    set_rs(1, 5'd10);
    chk("ld_nonpending_data", rdata(1), 32'hABCD);
    chk("ld_nonpending_pend", 32'(rs_pending[1]), 32'd0);

    // Reset mid-run with reg 9 pending.
    rsv = 5'd11; rsv_enable = 1'b1;
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("midrun_ready", 32'(ready), 32'd0);
    tick();
    rst = 1'b0;
    wait_ready("midrun_sweep");
    set_rs(0, 5'd9);
    set_rs(1, 5'd11);
    chk("midrun_pend9", 32'(rs_pending[0]), 32'd0);
    chk("midrun_pend11", 32'(rs_pending[1]), 32'd0);
    set_rs(0, 5'd7);
    chk("midrun_data7", rdata(0), 32'h0);

    // Reset mid-sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("midsweep_notready", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready("midsweep_restart");

    // Load completion read in the same cycle.
    ld = 5'd12; ld_data_in = 32'hA5; ld_write_enable = 1'b1;
    set_rs(0, 5'd12);
`ifdef REGISTERS_SB_BYPASS_EN
    chk("ld_fwd", rdata(0), 32'hA5);
`else
    chk("ld_fwd", rdata(0), 32'h0);
`endif
    tick();
    idle();
    chk("ld_after", rdata(0), 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
